sys_arr_weight_loader: RTL and testbench
========================================

Name: sys_arr_weight_loader

Overview:
Upstream feeder for the top row of the systolic array. It drives the top row's weight-in bus and per-PE weight-write bits.
- Accepts one row of weights per handshake from the host/DMA side (row 0 = top row first) into an internal buffer of num_rows entries.
- Once the buffer holds all num_rows rows, it shifts them into the array bottom-row-first, one row per cycle, with all wwrite bits high. Each row therefore ends up resident in its PE row after the shift.
- Signals completion with a one-cycle done pulse; busy gates array activation while the load is in progress.

Parameters:
row_width, 2, PEs per array row (columns); matches the array row instance
num_rows, 2, number of array rows to load (rows per weight set), >=1
weight_width, 8*row_width, localparam, bits per weight row; PE at column c uses bits [8c+7:8c]

Ports:
clock  input  1  single clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  pulse; begins a load when idle, ignored otherwise
wdata  input  weight_width  one weight row; column 0 in LSBs
wvalid  input  1  wdata valid
wready  output  1  loader accepts wdata this cycle
win  output  weight_width  registered weight row to top array row
wwrite  output  row_width  registered per-PE weight write enables to top array row
busy  output  1  load in progress; array must not be activated
done  output  1  one-cycle pulse when last row has been shifted in

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0, wready=0, win=0, wwrite=0, busy=0, done=0. Buffer contents are not cleared; they are don't-care.
- Reset mid-load aborts the load immediately. A fresh start is required afterwards.
- FSM states are IDLE, FILL, SHIFT, DONE. Index counter width is max(1,$clog2(num_rows)).
- IDLE:
  - wready=0.
  - start=1 -> FILL with cnt=0, busy=1 from the next cycle.
- FILL:
  - wready=1 (combinational from state).
  - Each cycle with wvalid&&wready: buf[cnt]<=wdata, cnt++.
  - On the handshake with cnt==num_rows-1 -> SHIFT with cnt=num_rows-1. No further handshakes are accepted.
  - Gaps in wvalid are allowed, and FILL waits indefinitely.
- SHIFT:
  - Each cycle: win<=buf[cnt], wwrite<={row_width{1'b1}}, cnt--.
  - At cnt==0 -> DONE.
  - Result: the first beat (buf[num_rows-1]) is visible on win the cycle after the final FILL handshake. The beats buf[num_rows-1]..buf[0] then appear on num_rows consecutive cycles with no bubbles.
- DONE:
  - win<=0, wwrite<=0, done<=1 (visible for exactly one cycle, the cycle after the last beat), then -> IDLE.
  - busy stays 1 through the done cycle and is 0 the following cycle.
- start while not IDLE is ignored. start in the same cycle as done is also ignored (the loader is not yet IDLE).
- num_rows==1: the single FILL handshake is followed by one SHIFT beat, then DONE.
- wdata is stored unmodified: no sign extension or arithmetic. Weights are treated as opaque 8-bit signed fields.
- wwrite is all-ones or all-zeros. No partial-column loads.

Decomposition:
- Shared package sys_arr_pkg: DATA_W=8, SUM_W=16 (shared with the PE/array rows), and the loader state enum (IDLE, FILL, SHIFT, DONE).
- One sub-module, sys_arr_wbuf: num_rows x weight_width register file.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
- The FSM, counter and output registers live in the top module.

Test Plan:
- Reset release, no start for 10 cycles -> wready=0, win=0, wwrite=0, busy=0, done=0 throughout.
- row_width=2, num_rows=3: start, then rows 16'h0201, 16'h0403, 16'h0605 on back-to-back cycles -> the next 3 cycles show win=0605, 0403, 0201 with wwrite=2'b11; the following cycle shows win=0, wwrite=0, done=1; busy=0 one cycle later.
- Same load with wvalid low for 4 cycles between rows 1 and 2 -> wready stays 1, no extra buffer writes, identical output sequence.
- start pulsed during FILL and during SHIFT -> no effect; exactly one done pulse and the same win sequence.
- reset_n asserted mid-SHIFT after 1 beat -> outputs 0 asynchronously, state IDLE. A new start plus 3 rows (11..33 pattern) loads correctly with no stale beats.
- num_rows=1 build: start, one row 16'hBEEF -> one beat win=BEEF with wwrite=2'b11, then done=1.

Source files
------------

// File: rtl/sys_arr_pkg.sv
// Shared definitions for the systolic array blocks.
// - DATA_W : width of one weight / activation field
// - SUM_W  : width of a PE partial sum
// - ld_state_e : state encoding of the top-row weight loader
// - idx_width(): index counter width for an n-entry structure, at least 1 bit
package sys_arr_pkg;

    localparam int DATA_W = 8;
    localparam int SUM_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    // Counter width for n entries; a single-entry structure still needs one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sys_arr_wbuf.sv
// Weight row buffer: DEPTH x WIDTH register file.
// Ports:
//   clk_i            : clock, write on rising edge
//   we_i/waddr_i/wdata_i : synchronous write port
//   raddr_i/rdata_o  : asynchronous read port (addresses >= DEPTH read as 0)
// Contents are never reset; the loader always rewrites every entry it reads.
module sys_arr_wbuf
    import sys_arr_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    parameter int AW    = 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write; out-of-range addresses are dropped.
    always_ff @(posedge clk_i) begin
        if (we_i && (int'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read with a defined value for unused address codes.
    always_comb begin
        rdata_o = {WIDTH{1'b0}};
        if (int'(raddr_i) < DEPTH) begin
            rdata_o = mem_q[raddr_i];
        end else begin
            rdata_o = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/sys_arr_weight_loader.sv
// Top-row weight loader for the systolic array.
// Collects num_rows weight rows from the host side (row 0 first), then
// shifts them into the array bottom row first, one row per cycle, with all
// weight-write bits set, so each row ends up resident in its own PE row.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : begins a load when idle
//   wdata/wvalid   : weight row input (column 0 in LSBs), wready accepts it
//   win/wwrite     : registered weight row and write enables to the top array row
//   busy           : load in progress, array must not be activated
//   done           : one-cycle pulse after the last row has been shifted in
module sys_arr_weight_loader
    import sys_arr_pkg::*;
#(
    parameter int  row_width    = 2,
    parameter int  num_rows     = 2,
    localparam int weight_width = DATA_W * row_width
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [weight_width-1:0] wdata,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [weight_width-1:0] win,
    output logic [row_width-1:0]    wwrite,
    output logic                    busy,
    output logic                    done
);

    localparam int             CNT_W    = idx_width(num_rows);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(num_rows - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ld_state_e               state_q,  state_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic [weight_width-1:0] win_q,    win_d;
    logic [row_width-1:0]    wwrite_q, wwrite_d;
    logic                    busy_q,   busy_d;
    logic                    done_q,   done_d;

    logic                    hs_s;
    logic                    buf_we_s;
    logic [CNT_W-1:0]        buf_raddr_s;
    logic [weight_width-1:0] buf_rdata_s;

    // Row storage; written in FILL at the running index.
    sys_arr_wbuf #(
        .DEPTH (num_rows),
        .WIDTH (weight_width),
        .AW    (CNT_W)
    ) u_wbuf (
        .clk_i   (clock),
        .we_i    (buf_we_s),
        .waddr_i (cnt_q),
        .wdata_i (wdata),
        .raddr_i (buf_raddr_s),
        .rdata_o (buf_rdata_s)
    );

    assign wready = (state_q == ST_FILL);
    assign hs_s   = wvalid && (state_q == ST_FILL);

    // In SHIFT cnt_q names the row currently on win, so the buffer is read one
    // row ahead. The top row goes straight from wdata to win on the final
    // handshake, which removes a bubble before the first beat.
    assign buf_raddr_s = cnt_q - CNT_ONE;

    // Next-state and output-register logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        wwrite_d = wwrite_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        buf_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                win_d    = {weight_width{1'b0}};
                wwrite_d = {row_width{1'b0}};
                if (start) begin
                    state_d = ST_FILL;
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_FILL: begin
                busy_d = 1'b1;
                if (hs_s) begin
                    buf_we_s = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d  = ST_SHIFT;
                        cnt_d    = LAST_IDX;
                        win_d    = wdata;
                        wwrite_d = {row_width{1'b1}};
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d  = ST_DONE;
                    win_d    = {weight_width{1'b0}};
                    wwrite_d = {row_width{1'b0}};
                    done_d   = 1'b1;
                end else begin
                    win_d    = buf_rdata_s;
                    wwrite_d = {row_width{1'b1}};
                    cnt_d    = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                // busy is still high while done is visible; drop it now.
                state_d  = ST_IDLE;
                cnt_d    = CNT_ZERO;
                win_d    = {weight_width{1'b0}};
                wwrite_d = {row_width{1'b0}};
                busy_d   = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = CNT_ZERO;
                win_d    = {weight_width{1'b0}};
                wwrite_d = {row_width{1'b0}};
                busy_d   = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            win_q    <= {weight_width{1'b0}};
            wwrite_q <= {row_width{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            wwrite_q <= wwrite_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign win    = win_q;
    assign wwrite = wwrite_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sys_arr_weight_loader.sv
module tb_sys_arr_weight_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start3 = 1'b0, wvalid3 = 1'b0;
    logic [15:0] wdata3 = 16'h0000;
    logic        wready3, busy3, done3;
    logic [15:0] win3;
    logic [1:0]  wwrite3;

    logic        start1 = 1'b0, wvalid1 = 1'b0;
    logic [15:0] wdata1 = 16'h0000;
    logic        wready1, busy1, done1;
    logic [15:0] win1;
    logic [1:0]  wwrite1;

    sys_arr_weight_loader #(.row_width(2), .num_rows(3)) dut3 (
        .clock(clk), .reset_n(rst_n), .start(start3), .wdata(wdata3), .wvalid(wvalid3),
        .wready(wready3), .win(win3), .wwrite(wwrite3), .busy(busy3), .done(done3)
    );

    sys_arr_weight_loader #(.row_width(2), .num_rows(1)) dut1 (
        .clock(clk), .reset_n(rst_n), .start(start1), .wdata(wdata1), .wvalid(wvalid1),
        .wready(wready1), .win(win1), .wwrite(wwrite1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;

    // Load records: start cycle s, final-handshake cycle f (-1 until known), rows.
    bit          m3_act = 1'b0, m1_act = 1'b0;
    int          m3_s = 0, m3_f = -1, m1_s = 0, m1_f = -1;
    logic [15:0] m3_rows [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] m1_rows [3] = '{16'h0, 16'h0, 16'h0};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    // Expected outputs from the load timeline: wready from s+1 through f,
    // beats rows[n-1]..rows[0] on f+1..f+n, done on f+n+1, busy s+1..f+n+1.
    task automatic cmp_dut(input string nm, input bit act, input int s, input int f, input int n,
                           input logic [15:0] rows [3], input logic wr, input logic by,
                           input logic dn, input logic [15:0] wn, input logic [1:0] ww);
        int c;
        logic e_wr, e_by, e_dn;
        logic [15:0] e_wn;
        logic [1:0] e_ww;
        c = cyc;
        e_wr = act && (c > s) && (f < 0 || c <= f);
        e_by = act && (c > s) && (f < 0 || c <= f + n + 1);
        e_dn = act && (f >= 0) && (c == f + n + 1);
        if (act && f >= 0 && c >= f + 1 && c <= f + n) begin
            e_wn = rows[n - 1 - (c - f - 1)];
            e_ww = 2'b11;
        end else begin
            e_wn = 16'h0000;
            e_ww = 2'b00;
        end
        chk({nm, ".wready"}, 32'(wr), 32'(e_wr));
        chk({nm, ".busy"},   32'(by), 32'(e_by));
        chk({nm, ".done"},   32'(dn), 32'(e_dn));
        chk({nm, ".win"},    32'(wn), 32'(e_wn));
        chk({nm, ".wwrite"}, 32'(ww), 32'(e_ww));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp_dut("n3", m3_act, m3_s, m3_f, 3, m3_rows, wready3, busy3, done3, win3, wwrite3);
            cmp_dut("n1", m1_act, m1_s, m1_f, 1, m1_rows, wready1, busy1, done1, win1, wwrite1);
        end
    end

    task automatic zero_chk(input string nm);
        chk({nm, ".win3"}, 32'(win3), 32'h0);
        chk({nm, ".wwrite3"}, 32'(wwrite3), 32'h0);
        chk({nm, ".busy3"}, 32'(busy3), 32'h0);
        chk({nm, ".done3"}, 32'(done3), 32'h0);
        chk({nm, ".wready3"}, 32'(wready3), 32'h0);
        chk({nm, ".win1"}, 32'(win1), 32'h0);
        chk({nm, ".busy1"}, 32'(busy1), 32'h0);
    endtask

    // Drives a 3-row load; returns #1 after the edge that takes the last row.
    task automatic load3(input logic [15:0] r [3], input int g [3], input bit stray);
        start3 = 1'b1; m3_s = cyc; m3_f = -1; m3_rows = r; m3_act = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < g[i]; k++) begin
                wvalid3 = 1'b0; wdata3 = 16'($urandom);
                start3 = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                @(posedge clk); #1;
            end
            start3 = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            wvalid3 = 1'b1; wdata3 = r[i];
            if (i == 2) m3_f = cyc;
            @(posedge clk); #1;
        end
        wvalid3 = 1'b0; start3 = 1'b0;
    endtask

    // Covers the shift and done cycles, optionally with ignored start/wvalid.
    task automatic tail3(input bit stray);
        for (int k = 0; k < 4; k++) begin
            start3 = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            wvalid3 = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            wdata3 = 16'($urandom);
            @(posedge clk); #1;
        end
        start3 = 1'b0; wvalid3 = 1'b0;
    endtask

    task automatic load1(input logic [15:0] r, input int gap, input bit stray);
        start1 = 1'b1; m1_s = cyc; m1_f = -1; m1_rows[0] = r; m1_act = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int k = 0; k < gap; k++) begin
            wvalid1 = 1'b0; wdata1 = 16'($urandom);
            start1 = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        start1 = 1'b0; wvalid1 = 1'b1; wdata1 = r; m1_f = cyc;
        @(posedge clk); #1;
        wvalid1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start1 = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            wvalid1 = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        start1 = 1'b0; wvalid1 = 1'b0;
    endtask

    initial begin
        logic [15:0] a [3];
        logic [15:0] b [3];
        logic [15:0] rr [3];
        int g0 [3];
        int g1 [3];
        int g2 [3];
        int gr [3];
        a = '{16'h0201, 16'h0403, 16'h0605};
        b = '{16'h1111, 16'h2222, 16'h3333};
        g0 = '{0, 0, 0};
        g1 = '{0, 0, 4};
        g2 = '{0, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        zero_chk("in_reset");
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        zero_chk("idle10");

        // Directed load with literal expectations.
        load3(a, g0, 1'b0);
        @(negedge clk); chk("d.beat0", 32'(win3), 32'h0605); chk("d.ww0", 32'(wwrite3), 32'h3);
        @(negedge clk); chk("d.beat1", 32'(win3), 32'h0403); chk("d.ww1", 32'(wwrite3), 32'h3);
        @(negedge clk); chk("d.beat2", 32'(win3), 32'h0201); chk("d.ww2", 32'(wwrite3), 32'h3);
        @(negedge clk); chk("d.done", 32'(done3), 32'h1); chk("d.win0", 32'(win3), 32'h0);
        chk("d.busy_done", 32'(busy3), 32'h1); chk("d.ww_off", 32'(wwrite3), 32'h0);
        @(negedge clk); chk("d.busy_off", 32'(busy3), 32'h0); chk("d.done_off", 32'(done3), 32'h0);
        @(posedge clk); #1;

        // Gap of 4 cycles before row 2, then stray starts in FILL/SHIFT/DONE.
        load3(a, g1, 1'b0);
        tail3(1'b0);
        load3(a, g2, 1'b1);
        tail3(1'b1);

        // Reset after the first beat aborts the load.
        load3(a, g0, 1'b0);
        #1;
        rst_n = 1'b0; m3_act = 1'b0; m1_act = 1'b0;
        #1;
        zero_chk("mid_rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        load3(b, g0, 1'b0);
        @(negedge clk); chk("r.beat0", 32'(win3), 32'h3333);
        @(posedge clk); #1;
        tail3(1'b0);

        // Single-row build.
        load1(16'hBEEF, 0, 1'b0);
        chk("n1.done_seen", 32'(busy1), 32'h0);
        m1_act = 1'b0;
        start1 = 1'b1; m1_s = cyc; m1_f = -1; m1_rows[0] = 16'hBEEF; m1_act = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; wvalid1 = 1'b1; wdata1 = 16'hBEEF; m1_f = cyc;
        @(posedge clk); #1;
        wvalid1 = 1'b0;
        @(negedge clk); chk("s.beat", 32'(win1), 32'hBEEF); chk("s.ww", 32'(wwrite1), 32'h3);
        @(negedge clk); chk("s.done", 32'(done1), 32'h1); chk("s.win0", 32'(win1), 32'h0);
        @(negedge clk); chk("s.busy_off", 32'(busy1), 32'h0);
        @(posedge clk); #1;

        // Randomized loads.
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 3; i++) begin
                rr[i] = 16'($urandom);
                gr[i] = int'($urandom_range(0, 3));
            end
            load3(rr, gr, 1'($urandom_range(0, 1)));
            tail3(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        for (int n = 0; n < 8; n++) begin
            load1(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
